// File: rtl/reg_file.sv
// Architectural register file with rename tags: tracks which RoB entry produces each
// register, retires committed values, and resolves source operands (stored, bypassed or forwarded).
module reg_file #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [ROB_W-1:0] commit_rob_id,
    input  logic [XLEN-1:0]  commit_value,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [ROB_W-1:0] get_rob_id1,
    output logic [ROB_W-1:0] get_rob_id2,
    input  logic             get_ready1,
    input  logic [XLEN-1:0]  get_value1,
    input  logic             get_ready2,
    input  logic [XLEN-1:0]  get_value2,
    output logic             rs1_ready,
    output logic [XLEN-1:0]  rs1_value,
    output logic [ROB_W-1:0] rs1_dep,
    output logic             rs2_ready,
    output logic [XLEN-1:0]  rs2_value,
    output logic [ROB_W-1:0] rs2_dep
);

    // x0 is hard-wired, so storage covers x1..x31 only.
    logic [XLEN-1:0]  value_q [1:31];
    logic [XLEN-1:0]  value_d [1:31];
    logic [ROB_W-1:0] tag_q   [1:31];
    logic [ROB_W-1:0] tag_d   [1:31];
    logic [31:1]      busy_q;
    logic [31:1]      busy_d;

    // Packed {ready, value, dep} for one source operand, evaluated against pre-issue state.
    function automatic logic [XLEN+ROB_W:0] read_port(
        input logic [4:0]      rs,
        input logic            get_ready,
        input logic [XLEN-1:0] get_value
    );
        logic             ready;
        logic [XLEN-1:0]  value;
        logic [ROB_W-1:0] dep;
        ready = 1'b1;
        value = '0;
        dep   = '0;
        if (rst && rs != 5'd0) begin
            if (!busy_q[rs]) begin
                value = value_q[rs];
            end else if (commit_valid && commit_rob_id == tag_q[rs]) begin
                value = commit_value;
            end else if (get_ready) begin
                value = get_value;
            end else begin
                ready = 1'b0;
                dep   = tag_q[rs];
            end
        end
        return {ready, value, dep};
    endfunction

    always_comb begin
        {rs1_ready, rs1_value, rs1_dep} = read_port(rs1, get_ready1, get_value1);
        {rs2_ready, rs2_value, rs2_dep} = read_port(rs2, get_ready2, get_value2);
        get_rob_id1 = (rst && rs1 != 5'd0) ? tag_q[rs1] : '0;
        get_rob_id2 = (rst && rs2 != 5'd0) ? tag_q[rs2] : '0;
    end

    always_comb begin
        // NOTE: every next-state variable gets a hold default first, so no path can infer a latch.
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rdy) begin
            if (commit_valid && commit_rd != 5'd0) begin
                value_d[commit_rd] = commit_value;
                if (tag_q[commit_rd] == commit_rob_id) begin
                    busy_d[commit_rd] = 1'b0;
                end
            end
            // Later assignments win: issue overrides a same-rd release, clear overrides both.
            if (clear) begin
                busy_d = '0;
                for (int i = 1; i < 32; i++) begin
                    tag_d[i] = '0;
                end
            end else if (issue_valid && issue_rd != 5'd0) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            // NOTE: the value array is reset too, because reads during and after reset must return 0.
            for (int i = 1; i < 32; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge state.
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a spec-level register/tag model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reg_file;

    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             clear;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [ROB_W-1:0] issue_rob_id;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [ROB_W-1:0] commit_rob_id;
    logic [XLEN-1:0]  commit_value;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [ROB_W-1:0] get_rob_id1;
    logic [ROB_W-1:0] get_rob_id2;
    logic             get_ready1;
    logic [XLEN-1:0]  get_value1;
    logic             get_ready2;
    logic [XLEN-1:0]  get_value2;
    logic             rs1_ready;
    logic [XLEN-1:0]  rs1_value;
    logic [ROB_W-1:0] rs1_dep;
    logic             rs2_ready;
    logic [XLEN-1:0]  rs2_value;
    logic [ROB_W-1:0] rs2_dep;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value),
        .rs1(rs1), .rs2(rs2),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .get_ready1(get_ready1), .get_value1(get_value1),
        .get_ready2(get_ready2), .get_value2(get_value2),
        .rs1_ready(rs1_ready), .rs1_value(rs1_value), .rs1_dep(rs1_dep),
        .rs2_ready(rs2_ready), .rs2_value(rs2_value), .rs2_dep(rs2_dep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Architectural model: one value/busy/tag triple per register, x0 never written.
    logic [XLEN-1:0]  m_val  [32] = '{default: '0};
    logic             m_busy [32] = '{default: 1'b0};
    logic [ROB_W-1:0] m_tag  [32] = '{default: '0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i]  <= '0;
                m_busy[i] <= 1'b0;
                m_tag[i]  <= '0;
            end
        end else if (rdy) begin
            if (commit_valid && commit_rd != 0) begin
                m_val[commit_rd] <= commit_value;
                if (m_tag[commit_rd] == commit_rob_id) m_busy[commit_rd] <= 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] <= 1'b0;
                    m_tag[i]  <= '0;
                end
            end else if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] <= 1'b1;
                m_tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    typedef struct packed {
        logic             ready;
        logic [XLEN-1:0]  value;
        logic [ROB_W-1:0] dep;
        logic [ROB_W-1:0] id;
    } rd_t;

    function automatic rd_t model_read(input logic [4:0] rs, input logic gr, input logic [XLEN-1:0] gv);
        rd_t r;
        r = '0;
        r.ready = 1'b1;
        if (!rst || rs == 0) return r;
        r.id = m_tag[rs];
        if (!m_busy[rs])                                     r.value = m_val[rs];
        else if (commit_valid && commit_rob_id == m_tag[rs]) r.value = commit_value;
        else if (gr)                                         r.value = gv;
        else begin
            r.ready = 1'b0;
            r.dep   = m_tag[rs];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        rd_t e1;
        rd_t e2;
        e1 = model_read(rs1, get_ready1, get_value1);
        e2 = model_read(rs2, get_ready2, get_value2);
        check("cyc_rs1_ready", rs1_ready, e1.ready);
        check("cyc_rs1_value", rs1_value, e1.value);
        check("cyc_rs1_dep", rs1_dep, e1.dep);
        check("cyc_get_rob_id1", get_rob_id1, e1.id);
        check("cyc_rs2_ready", rs2_ready, e2.ready);
        check("cyc_rs2_value", rs2_value, e2.value);
        check("cyc_rs2_dep", rs2_dep, e2.dep);
        check("cyc_get_rob_id2", get_rob_id2, e2.id);
    end

    task automatic idle();
        rdy = 1'b1; clear = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
        get_ready1 = 1'b0; get_value1 = '0; get_ready2 = 1'b0; get_value2 = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [ROB_W-1:0] id);
        issue_valid = 1'b1; issue_rd = rd; issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [ROB_W-1:0] id, input logic [XLEN-1:0] v);
        commit_valid = 1'b1; commit_rd = rd; commit_rob_id = id; commit_value = v;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rs1 = 5'd5; rs2 = 5'd0;
        #2;
        check("rst_rs1_ready", rs1_ready, 1'b1);
        check("rst_rs1_value", rs1_value, 32'h0);
        check("rst_get_rob_id1", get_rob_id1, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // Store 0x1234 in x5, then reset mid-cycle and see it vanish at once.
        advance(); commit(5'd5, 4'd0, 32'h1234);
        advance(); rs1 = 5'd5;
        settle(); check("x5_before_rst", rs1_value, 32'h1234);
        #2 rst = 1'b0;
        #1;
        check("x5_async_rst_value", rs1_value, 32'h0);
        check("x5_async_rst_ready", rs1_ready, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;

        for (int i = 1; i < 32; i++) begin
            advance(); rs1 = 5'(i); rs2 = 5'(32 - i);
            settle();
            check("post_rst_value", rs1_value, 32'h0);
            check("post_rst_ready", rs1_ready, 1'b1);
        end

        // Issue x3 -> rob 2, wait, then commit with bypass, then stored.
        advance(); issue(5'd3, 4'd2);
        advance(); rs1 = 5'd3; rs2 = 5'd0;
        settle();
        check("x3_busy_ready", rs1_ready, 1'b0);
        check("x3_busy_dep", rs1_dep, 4'd2);
        check("x3_get_rob_id1", get_rob_id1, 4'd2);
        advance(); commit(5'd3, 4'd2, 32'hDEAD);
        settle();
        check("x3_bypass_ready", rs1_ready, 1'b1);
        check("x3_bypass_value", rs1_value, 32'hDEAD);
        advance();
        settle();
        check("x3_stored_value", rs1_value, 32'hDEAD);
        check("x3_stored_dep", rs1_dep, 4'd0);

        // Stale commit on x7.
        advance(); issue(5'd7, 4'd1);
        advance(); issue(5'd7, 4'd4);
        advance(); commit(5'd7, 4'd1, 32'h11); rs2 = 5'd7;
        settle();
        check("x7_stale_ready", rs2_ready, 1'b0);
        advance();
        settle();
        check("x7_still_busy", rs2_ready, 1'b0);
        check("x7_dep", rs2_dep, 4'd4);
        check("x7_get_rob_id2", get_rob_id2, 4'd4);

        // Same-cycle commit and reissue on x9; read sees pre-issue state.
        advance(); issue(5'd9, 4'd5); rs1 = 5'd9; rs2 = 5'd0;
        advance(); commit(5'd9, 4'd5, 32'h55); issue(5'd9, 4'd6);
        settle();
        check("x9_pre_issue_bypass", rs1_value, 32'h55);
        advance();
        settle();
        check("x9_reissued_ready", rs1_ready, 1'b0);
        check("x9_reissued_dep", rs1_dep, 4'd6);

        // RoB forward on x4, then flush with a dropped issue of x8.
        advance(); issue(5'd4, 4'd3);
        advance(); rs1 = 5'd4; rs2 = 5'd4; get_ready1 = 1'b1; get_value1 = 32'h77;
        settle();
        check("x4_forward_ready", rs1_ready, 1'b1);
        check("x4_forward_value", rs1_value, 32'h77);
        check("x4_port2_dep", rs2_dep, 4'd3);
        advance(); clear = 1'b1; issue(5'd8, 4'd9);
        advance(); rs1 = 5'd7; rs2 = 5'd9;
        settle();
        check("x7_after_clear", rs1_value, 32'h11);
        check("x9_after_clear", rs2_value, 32'h55);
        check("x9_after_clear_ready", rs2_ready, 1'b1);
        advance(); rs1 = 5'd8; rs2 = 5'd4;
        settle();
        check("x8_dropped_ready", rs1_ready, 1'b1);
        check("x8_dropped_id", get_rob_id1, 4'd0);
        check("x4_cleared_ready", rs2_ready, 1'b1);

        // Reading own destination in the issue cycle does not self-depend.
        advance(); issue(5'd10, 4'd8); rs1 = 5'd10;
        settle();
        check("x10_self_ready", rs1_ready, 1'b1);
        advance();
        settle();
        check("x10_dep", rs1_dep, 4'd8);

        // x0 writes are ignored.
        advance(); issue(5'd0, 4'd5); commit(5'd0, 4'd0, 32'hFF);
        advance(); rs1 = 5'd0; rs2 = 5'd0;
        settle();
        check("x0_value", rs1_value, 32'h0);
        check("x0_ready", rs2_ready, 1'b1);

        // Stall: nothing changes while rdy is low.
        advance(); rdy = 1'b0; issue(5'd2, 4'd7); commit(5'd2, 4'd0, 32'hAB);
        advance(); rs1 = 5'd2;
        settle();
        check("x2_stall_ready", rs1_ready, 1'b1);
        check("x2_stall_value", rs1_value, 32'h0);
        check("x2_stall_id", get_rob_id1, 4'd0);

        advance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
